mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 tb/tb_mem_access_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: passes ALU results through to writeback and runs
// single outstanding load/store transactions with a wait timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_update,
  input  logic [36:0] in_data,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic        is_ld, is_st, is_rsv;

  assign is_ld  = (in_data[1:0] == 2'b01);
  assign is_st  = (in_data[1:0] == 2'b10);
  assign is_rsv = (in_data[1:0] == 2'b11);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    err_d       = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = 8'd0;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        wb_rd_d = in_data[4:2];
        unique case (1'b1)
          is_ld: begin
            state_d    = WAIT_MEM;
            cnt_d      = 8'd0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = in_data[20:5];
          end
          is_st: begin
            state_d     = WAIT_MEM;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = in_data[20:5];
            mem_wdata_d = in_data[36:21];
          end
          default: begin
            wb_valid_d = 1'b1;
            wb_we_d    = in_update & ~is_rsv;
            wb_data_d  = in_data[20:5];
          end
        endcase
      end
    end else begin
      // mem_we_q still tells load from store while waiting
      if (mem_ready) begin
        state_d    = IDLE;
        cnt_d      = 8'd0;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        wb_valid_d = 1'b1;
        wb_we_d    = ~mem_we_q;
        if (!mem_we_q) wb_data_d = mem_rdata;
      end else if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        err_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 3'd0;
      wb_data_q   <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign stall_out = (state_q == WAIT_MEM);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks are queued
// when stimulus is driven and matched when wb_valid pulses.
module tb_mem_access_stage;

  typedef struct {
    logic        we;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        chk_data;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_update;
  logic [36:0] in_data;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        wb_valid;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        err;

  exp_t q[$];
  int checks;
  int failures;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_update(in_update), .in_data(in_data),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] pack(input logic [15:0] a,
                                       input logic [15:0] res,
                                       input logic [2:0] rd,
                                       input logic [1:0] op);
    return {a, res, rd, op};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // writeback monitor: every wb_valid pulse must match the queue head
  always @(posedge clk) begin
    #2;
    if (wb_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got rd=%0d data=%h exp=none", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wb_we !== e.we || wb_rd !== e.rd ||
            (e.chk_data && wb_data !== e.data)) begin
          failures++;
          $display("FAIL wb_match got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                   wb_we, wb_rd, wb_data, e.we, e.rd, e.data);
        end
      end
    end
    if (err === 1'b1 && wb_valid === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL err_with_wb got=1 exp=0");
    end
  end

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_update = 1'b0;
    in_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata,
         wb_valid, wb_we, wb_rd, wb_data, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {stall_out, mem_req, mem_we, mem_addr, mem_wdata,
                wb_valid, wb_we, wb_rd, wb_data, err});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    in_valid = 1'b1; in_update = 1'b1; mem_ready = 1'b1;
    in_data = pack(16'h0, 16'h1234, 3'd5, 2'b00);
    q.push_back('{1'b1, 3'd5, 16'h1234, 1'b1});
    cyc();
    checks++;
    if (wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL alu_wb_valid got=%b exp=1", wb_valid);
    end
    in_data = pack(16'h0, 16'h7777, 3'd6, 2'b11);
    q.push_back('{1'b0, 3'd6, 16'h7777, 1'b1});
    cyc();
    in_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL alu_no_mem got req=%b stall=%b exp 0 0", mem_req, stall_out);
    end
    mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] r;
      logic [1:0]  op;
      logic        up;
      r  = 16'($urandom);
      op = (i == 2) ? 2'b11 : 2'b00;
      up = (i != 1);
      in_valid = 1'b1; in_update = up;
      in_data = pack(16'($urandom), r, 3'(i + 1), op);
      q.push_back('{up && (op != 2'b11), 3'(i + 1), r, 1'b1});
      cyc();
      checks++;
      if (wb_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_wb_valid[%0d] got=%b exp=1", i, wb_valid);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_load();
    in_valid = 1'b1; in_update = 1'b1;
    in_data = pack(16'h0, 16'h0040, 3'd2, 2'b01);
    cyc();
    // keep an ALU op waiting; it must not be taken while stalled
    in_data = pack(16'h0, 16'h5555, 3'd7, 2'b00);
    mem_rdata = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040 ||
          stall_out !== 1'b1 || wb_rd !== 3'd2) begin
        failures++;
        $display("FAIL load_wait[%0d] got req=%b we=%b addr=%h stall=%b rd=%0d",
                 k, mem_req, mem_we, mem_addr, stall_out, wb_rd);
      end
      mem_ready = (k == 3);
      if (k == 3) q.push_back('{1'b1, 3'd2, 16'hBEEF, 1'b1});
      cyc();
    end
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    checks++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL load_done got req=%b stall=%b wbv=%b exp 0 0 1",
               mem_req, stall_out, wb_valid);
    end
    q.push_back('{1'b1, 3'd7, 16'h5555, 1'b1});
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_store();
    in_valid = 1'b1; in_update = 1'b0;
    in_data = pack(16'hA5A5, 16'h0010, 3'd3, 2'b10);
    cyc();
    in_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 ||
        mem_wdata !== 16'hA5A5) begin
      failures++;
      $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    q.push_back('{1'b0, 3'd3, 16'h0, 1'b0});
    cyc();
    mem_ready = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL store_done got we=%b req=%b wbv=%b exp 0 0 1",
               mem_we, mem_req, wb_valid);
    end
    cyc();
  endtask

  task automatic test_timeout();
    in_valid = 1'b1; in_update = 1'b1;
    in_data = pack(16'h0, 16'h0080, 3'd4, 2'b01);
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait[%0d] got req=%b err=%b exp 1 0", k, mem_req, err);
      end
      cyc();
    end
    checks++;
    if (err !== 1'b1 || stall_out !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort got err=%b stall=%b req=%b exp 1 0 0",
               err, stall_out, mem_req);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_pulse got=%b exp=0", err);
    end
    in_valid = 1'b1;
    in_data = pack(16'h0, 16'h0090, 3'd1, 2'b01);
    mem_rdata = 16'h1357;
    cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mem_ready = (k == 4);
      if (k == 4) q.push_back('{1'b1, 3'd1, 16'h1357, 1'b1});
      cyc();
    end
    mem_ready = 1'b0;
    checks++;
    if (err !== 1'b0 || wb_valid !== 1'b1 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_edge got err=%b wbv=%b stall=%b exp 0 1 0",
               err, wb_valid, stall_out);
    end
    cyc();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_update = 1'b1;
    in_data = pack(16'h0, 16'h00A0, 3'd5, 2'b01);
    cyc();
    in_valid = 1'b0;
    mem_ready = 1'b1; flush = 1'b1;
    cyc();
    mem_ready = 1'b0; flush = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || stall_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_wait got req=%b wbv=%b stall=%b exp 0 0 0",
               mem_req, wb_valid, stall_out);
    end
    in_valid = 1'b1; flush = 1'b1;
    in_data = pack(16'h0, 16'h4321, 3'd6, 2'b00);
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got wbv=%b exp=0", wb_valid);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_update = 1'b1;
    in_data = pack(16'h0, 16'h00C0, 3'd3, 2'b01);
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got req=%b stall=%b wbv=%b exp 0 0 0",
               mem_req, stall_out, wb_valid);
    end
    #3;
    resetn = 1'b1;
    in_valid = 1'b1;
    in_data = pack(16'h0, 16'h2468, 3'd1, 2'b00);
    q.push_back('{1'b1, 3'd1, 16'h2468, 1'b1});
    cyc();
    in_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h2468) begin
      failures++;
      $display("FAIL reset_release got wbv=%b data=%h exp 1 2468", wb_valid, wb_data);
    end
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_timeout();
    test_flush();
    test_reset_mid();
    repeat (3) cyc();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
